// File: rtl/sisc_pkg.sv
// Shared definitions for the SISC fetch stage: FSM encoding, instruction width
// and the default reset program counter.
package sisc_pkg;

    localparam int INSTR_W          = 32;
    localparam int DEFAULT_RESET_PC = 0;

    typedef enum logic [0:0] {
        S_FETCH = 1'b0,
        S_HOLD  = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_pc.sv
// Program counter register: a redirect load takes priority over an increment,
// and the increment wraps modulo 2^ADDR_W.
module fetch_pc
    import sisc_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int RESET_PC = DEFAULT_RESET_PC
) (
    input  logic              clk,
    input  logic              rst_f,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] load_addr_i,
    input  logic              inc_i,
    input  logic [ADDR_W-1:0] inc_base_i,
    output logic [ADDR_W-1:0] pc_o
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    // Next-PC selection
    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_addr_i;
        end else if (inc_i) begin
            pc_d = inc_base_i + ADDR_W'(1);
        end else begin
            pc_d = pc_q;
        end
    end

    // PC register
    always_ff @(posedge clk) begin
        if (!rst_f) begin
            pc_q <= ADDR_W'(RESET_PC);
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/sisc_fetch.sv
// SISC instruction fetch stage: request/ack transaction with instruction memory,
// instruction register with valid/ready handshake, and branch redirect with squash.
module sisc_fetch
    import sisc_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int RESET_PC = DEFAULT_RESET_PC
) (
    input  logic               clk,
    input  logic               rst_f,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] ir,
    output logic [ADDR_W-1:0]  ir_pc,
    output logic               ir_valid,
    input  logic               ir_ready,
    input  logic               br_taken,
    input  logic [ADDR_W-1:0]  br_addr
);

    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  req_addr_q, req_addr_d;
    logic               squash_q, squash_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic [ADDR_W-1:0]  ir_pc_q, ir_pc_d;
    logic               ir_valid_q, ir_valid_d;
    logic               imem_req_q, imem_req_d;
    logic               pc_load_s;
    logic               pc_inc_s;
    logic [ADDR_W-1:0]  pc_s;

    fetch_pc #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk         (clk),
        .rst_f       (rst_f),
        .load_i      (pc_load_s),
        .load_addr_i (br_addr),
        .inc_i       (pc_inc_s),
        .inc_base_i  (req_addr_q),
        .pc_o        (pc_s)
    );

    // Next-state logic; an ack is only honoured while a request is outstanding
    always_comb begin
        state_d    = state_q;
        req_addr_d = req_addr_q;
        squash_d   = squash_q;
        ir_d       = ir_q;
        ir_pc_d    = ir_pc_q;
        ir_valid_d = ir_valid_q;
        imem_req_d = imem_req_q;
        pc_load_s  = 1'b0;
        pc_inc_s   = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (!imem_req_q) begin
                    // First request after reset; a redirect before it is issued needs no squash
                    imem_req_d = 1'b1;
                    if (br_taken) begin
                        pc_load_s  = 1'b1;
                        req_addr_d = br_addr;
                    end else begin
                        req_addr_d = req_addr_q;
                    end
                end else if (imem_ack) begin
                    if (br_taken) begin
                        pc_load_s  = 1'b1;
                        req_addr_d = br_addr;
                        squash_d   = 1'b0;
                    end else if (squash_q) begin
                        squash_d   = 1'b0;
                        req_addr_d = pc_s;
                    end else begin
                        ir_d       = imem_rdata;
                        ir_pc_d    = req_addr_q;
                        ir_valid_d = 1'b1;
                        pc_inc_s   = 1'b1;
                        imem_req_d = 1'b0;
                        state_d    = S_HOLD;
                    end
                end else if (br_taken) begin
                    pc_load_s = 1'b1;
                    squash_d  = 1'b1;
                end else begin
                    squash_d = squash_q;
                end
            end
            S_HOLD: begin
                if (br_taken) begin
                    pc_load_s  = 1'b1;
                    req_addr_d = br_addr;
                    ir_valid_d = 1'b0;
                    imem_req_d = 1'b1;
                    state_d    = S_FETCH;
                end else if (ir_ready) begin
                    ir_valid_d = 1'b0;
                    req_addr_d = pc_s;
                    imem_req_d = 1'b1;
                    state_d    = S_FETCH;
                end else begin
                    state_d = S_HOLD;
                end
            end
            default: begin
                state_d    = S_FETCH;
                imem_req_d = 1'b0;
            end
        endcase
    end

    // State registers
    always_ff @(posedge clk) begin
        if (!rst_f) begin
            state_q    <= S_FETCH;
            req_addr_q <= ADDR_W'(RESET_PC);
            squash_q   <= 1'b0;
            ir_q       <= '0;
            ir_pc_q    <= '0;
            ir_valid_q <= 1'b0;
            imem_req_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_addr_q <= req_addr_d;
            squash_q   <= squash_d;
            ir_q       <= ir_d;
            ir_pc_q    <= ir_pc_d;
            ir_valid_q <= ir_valid_d;
            imem_req_q <= imem_req_d;
        end
    end

    assign imem_req  = imem_req_q;
    assign imem_addr = req_addr_q;
    assign ir        = ir_q;
    assign ir_pc     = ir_pc_q;
    assign ir_valid  = ir_valid_q;

endmodule

// File: doc/sisc_fetch.md
# sisc_fetch

Instruction fetch stage for the SISC processor. Holds the program counter, runs a request/acknowledge transaction with instruction memory, and registers the returned word into the instruction register that drives the `sisc` core's `ir` input. Accepts branch redirects from the control unit and presents each instruction with a valid/ready handshake so the core can stall fetch.

## Interface
Parameters:
- `ADDR_W`, 16, instruction memory word-address width
- `RESET_PC`, 0, PC value loaded at reset

Ports (one clock; reset is synchronous and active-low, named `clk` and `rst_f`):
- `clk`  in  1  system clock, all state updates on rising edge
- `rst_f`  in  1  synchronous active-low reset
- `imem_req`  out  1  fetch request to instruction memory
- `imem_addr`  out  ADDR_W  word address of outstanding request
- `imem_ack`  in  1  memory has `imem_rdata` valid this cycle
- `imem_rdata`  in  32  instruction word
- `ir`  out  32  instruction register, feeds `sisc.ir`
- `ir_pc`  out  ADDR_W  address of the word held in `ir`
- `ir_valid`  out  1  `ir` holds an instruction not yet consumed
- `ir_ready`  in  1  core consumes `ir` this cycle
- `br_taken`  in  1  redirect fetch to `br_addr`
- `br_addr`  in  ADDR_W  branch target

## Operation
- State: `pc` (next address to fetch), `req_addr`, `squash` flag, FSM {S_FETCH, S_HOLD}.
- Reset (`rst_f`=0 at edge): `pc`=RESET_PC, `req_addr`=RESET_PC, `ir`=0, `ir_pc`=0, `ir_valid`=0, `imem_req`=0, `squash`=0, state S_FETCH. Outputs hold these while `rst_f` is low.
- S_FETCH: `imem_req`=1, `imem_addr`=`req_addr`, both stable until ack. On `imem_ack`:
  - `squash`=0: `ir`<=`imem_rdata`, `ir_pc`<=`req_addr`, `ir_valid`<=1, `pc`<=`req_addr`+1, `imem_req`<=0, go S_HOLD.
  - `squash`=1: discard data, clear `squash`, `req_addr`<=`pc`, keep `imem_req`=1 (new request next cycle), stay S_FETCH.
- S_HOLD: `imem_req`=0, `ir` and `ir_valid` stable. On `ir_ready`: `ir_valid`<=0, `req_addr`<=`pc`, `imem_req`<=1, go S_FETCH.
- Redirect `br_taken`=1:
  - in S_HOLD: `pc`<=`br_addr`, `req_addr`<=`br_addr`, `ir_valid`<=0, go S_FETCH; takes priority over `ir_ready`.
  - in S_FETCH: `pc`<=`br_addr`; request in flight not abandoned (address stays stable); `squash`<=1 unless `imem_ack` same cycle, in which case data discarded and `req_addr`<=`br_addr` directly.
  - repeated redirects while squashing: latest `br_addr` wins.
- PC arithmetic modulo 2^ADDR_W; `pc`=2^ADDR_W−1 increments to 0.
- `imem_ack` while `imem_req`=0 is ignored.

## Timing
- First `imem_req` high in the cycle after the first edge with `rst_f`=1.
- `imem_ack` may arrive in any cycle `imem_req` is high, including the first.
- Zero-wait memory: ack cycle N -> `ir_valid` high from N+1; with `ir_ready` held high, next ack no earlier than N+2: peak one instruction per 2 cycles.
- Redirect in S_HOLD at edge N: request to `br_addr` in cycle N+1.
- Reset asserted mid-transaction: `imem_req` low after that edge; any late ack ignored.

## Structure
- `sisc_pkg`: FSM state encoding (S_FETCH, S_HOLD), instruction width 32, default `RESET_PC`.
- One natural sub-module: `fetch_pc` — PC register with load (redirect), increment, and reset value; FSM, squash, and IR stay in `sisc_fetch`.

## Test plan
- Reset then zero-wait memory returning addr+0x100, `ir_ready`=1 -> `imem_addr` 0,1,2 on successive fetches; `ir`=0x100,0x101,0x102, `ir_pc`=0,1,2; `ir_valid` every other cycle.
- `ir_ready`=0 for 5 cycles after first instruction -> `ir`, `ir_valid` stable, `imem_req`=0 throughout; fetch of addr 1 starts the cycle after `ir_ready` rises.
- Memory 3-cycle ack latency, `br_taken` with `br_addr`=0x40 during wait -> addr 1 held until ack, data dropped, next request to 0x40, `ir_pc`=0x40.
- `br_taken` (0x20) and `ir_ready` same cycle in S_HOLD -> `ir_valid` drops, next `imem_addr`=0x20.
- `br_addr`=0xFFFF, ADDR_W=16 -> after consume, next `imem_addr`=0x0000.
- `rst_f` low while request outstanding, ack arrives after -> `imem_req`=0, `ir_valid`=0, restart fetch at RESET_PC.
